// File: rtl/sbox_gf16_inverse_pkg.sv
// -----------------------------------------------------------------------------
// sbox_gf16_inverse_pkg
//   Shared GF(2^4) definitions for the composite-field inverse stage.
//   - GF16_POLY      : field polynomial x^4 + x + 1
//   - LAMBDA_DEFAULT : norm constant of x^2 + x + LAMBDA over GF(2^4)
//   - gf256c_t       : composite byte {q, p} = q*x + p
//   - gf16_xtime     : multiply by x, reduced
//   - gf16_sq        : squaring (linear over GF(2))
//   - gf16_inv       : 16-entry inverse table, 0 -> 0
// -----------------------------------------------------------------------------
package sbox_gf16_inverse_pkg;

   localparam logic [4:0] GF16_POLY      = 5'b10011;
   localparam logic [3:0] LAMBDA_DEFAULT = 4'hC;

   typedef struct packed {
      logic [3:0] q;
      logic [3:0] p;
   } gf256c_t;

   // x^4 folds back to x + 1, i.e. the low four bits of the polynomial.
   function automatic logic [3:0] gf16_xtime(input logic [3:0] a);
      return {a[2:0], 1'b0} ^ (a[3] ? GF16_POLY[3:0] : 4'h0);
   endfunction

   // (a3 x^3 + a2 x^2 + a1 x + a0)^2 = a3 x^6 + a2 x^4 + a1 x^2 + a0,
   // with x^4 = x + 1 and x^6 = x^3 + x^2.
   function automatic logic [3:0] gf16_sq(input logic [3:0] a);
      return {a[3], a[3] ^ a[1], a[2], a[2] ^ a[0]};
   endfunction

   function automatic logic [3:0] gf16_inv(input logic [3:0] a);
      logic [3:0] r;
      case (a)
         4'h0: r = 4'h0;
         4'h1: r = 4'h1;
         4'h2: r = 4'h9;
         4'h3: r = 4'hE;
         4'h4: r = 4'hD;
         4'h5: r = 4'hB;
         4'h6: r = 4'h7;
         4'h7: r = 4'h6;
         4'h8: r = 4'hF;
         4'h9: r = 4'h2;
         4'hA: r = 4'hC;
         4'hB: r = 4'h5;
         4'hC: r = 4'hA;
         4'hD: r = 4'h4;
         4'hE: r = 4'h3;
         default: r = 4'h8;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sbox_gf16_inverse_gf16_mul.sv
// -----------------------------------------------------------------------------
// sbox_gf16_inverse_gf16_mul
//   Combinational 4x4 multiplier in GF(2^4) mod x^4 + x + 1.
//   Ports:
//     a, b : input  [3:0]  operands
//     y    : output [3:0]  a * b
// -----------------------------------------------------------------------------
module sbox_gf16_inverse_gf16_mul
   import sbox_gf16_inverse_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] y
);

   logic [3:0] acc;
   logic [3:0] shifted;

   // Shift-and-add: accumulate a*x^i for every set bit of b.
   always_comb begin
      acc     = 4'h0;
      shifted = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) acc = acc ^ shifted;
         shifted = gf16_xtime(shifted);
      end
   end

   assign y = acc;

endmodule

// File: rtl/sbox_gf16_inverse.sv
// -----------------------------------------------------------------------------
// sbox_gf16_inverse
//   Pipelined multiplicative inverse in GF((2^4)^2), byte = {q, p} = q*x + p.
//     d  = LAMBDA*q^2 ^ q*p ^ p^2
//     di = d^-1 (0 -> 0)
//     q' = q*di,  p' = (p^q)*di
//   Configuration macro: SBOX_INV_MID_REG_EN
//     defined   : 3 stages (S1: d | S2: di | S3: out), latency 3, holds 3 bytes
//     undefined : d and di in one stage, latency 2, holds 2 bytes
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     in_valid/in_ready     : input handshake
//     in_data [7:0]         : composite byte {q, p}
//     in_tag  [TAG_W-1:0]   : sideband returned with the result
//     out_valid/out_ready   : output handshake
//     out_data [7:0]        : inverse byte {q', p'}
//     out_tag  [TAG_W-1:0]  : tag of the byte in out_data
//   Handshake: a transfer happens only on a rising edge where valid and ready
//   are both 1; a producer keeps valid (and its data) until that edge, and a
//   stalled output (out_valid & !out_ready) keeps out_data/out_tag unchanged.
//   Each stage loads when its slot is empty or is being drained the same cycle,
//   so bubbles collapse behind a stall and in_ready is combinational from
//   out_ready.
// -----------------------------------------------------------------------------
module sbox_gf16_inverse
   import sbox_gf16_inverse_pkg::*;
#(
   parameter logic [3:0] LAMBDA = LAMBDA_DEFAULT,
   parameter int         TAG_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [TAG_W-1:0] out_tag
);

   // ---------------------------------------------------------------------------
   // Norm of the incoming byte
   // ---------------------------------------------------------------------------
   gf256c_t    in_byte;
   logic [3:0] q_sq;
   logic [3:0] p_sq;
   logic [3:0] qp;
   logic [3:0] lq2;
   logic [3:0] d_in;

   assign in_byte = in_data;
   assign q_sq    = gf16_sq(in_byte.q);
   assign p_sq    = gf16_sq(in_byte.p);

   sbox_gf16_inverse_gf16_mul u_mul_qp (
      .a (in_byte.q),
      .b (in_byte.p),
      .y (qp)
   );

   sbox_gf16_inverse_gf16_mul u_mul_lq2 (
      .a (LAMBDA),
      .b (q_sq),
      .y (lq2)
   );

   assign d_in = lq2 ^ qp ^ p_sq;

   // ---------------------------------------------------------------------------
   // Stage readiness, computed back from the output
   // ---------------------------------------------------------------------------
   logic v2;
   logic v3;
   logic ready2;
   logic ready3;

   assign ready3 = !v3 || out_ready;
   assign ready2 = !v2 || ready3;

   // Source feeding stage 2: either the S1 register or the input port.
   logic             v_src;
   logic [3:0]       di_src;
   logic [3:0]       q_src;
   logic [3:0]       pq_src;
   logic [TAG_W-1:0] tag_src;

`ifdef SBOX_INV_MID_REG_EN
   // ---------------------------------------------------------------------------
   // S1: registers d, q, p^q, tag
   // ---------------------------------------------------------------------------
   logic             v1;
   logic             ready1;
   logic [3:0]       d1;
   logic [3:0]       q1;
   logic [3:0]       pq1;
   logic [TAG_W-1:0] tag1;

   assign ready1   = !v1 || ready2;
   assign in_ready = ready1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
      end else if (ready1) begin
         v1 <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (ready1 && in_valid) begin
         d1   <= d_in;
         q1   <= in_byte.q;
         pq1  <= in_byte.q ^ in_byte.p;
         tag1 <= in_tag;
      end
   end

   assign v_src   = v1;
   assign di_src  = gf16_inv(d1);
   assign q_src   = q1;
   assign pq_src  = pq1;
   assign tag_src = tag1;
`else
   // Norm and its inverse share one stage; stage 2 is the entry stage.
   assign in_ready = ready2;
   assign v_src    = in_valid;
   assign di_src   = gf16_inv(d_in);
   assign q_src    = in_byte.q;
   assign pq_src   = in_byte.q ^ in_byte.p;
   assign tag_src  = in_tag;
`endif

   // ---------------------------------------------------------------------------
   // S2: registers di, q, p^q, tag
   // ---------------------------------------------------------------------------
   logic [3:0]       di2;
   logic [3:0]       q2;
   logic [3:0]       pq2;
   logic [TAG_W-1:0] tag2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2 <= 1'b0;
      end else if (ready2) begin
         v2 <= v_src;
      end
   end

   always_ff @(posedge clk) begin
      if (ready2 && v_src) begin
         di2  <= di_src;
         q2   <= q_src;
         pq2  <= pq_src;
         tag2 <= tag_src;
      end
   end

   // ---------------------------------------------------------------------------
   // S3: output products and registers
   // ---------------------------------------------------------------------------
   logic [3:0]       q_out;
   logic [3:0]       p_out;
   logic [7:0]       out_data_r;
   logic [TAG_W-1:0] out_tag_r;

   sbox_gf16_inverse_gf16_mul u_mul_qo (
      .a (q2),
      .b (di2),
      .y (q_out)
   );

   sbox_gf16_inverse_gf16_mul u_mul_po (
      .a (pq2),
      .b (di2),
      .y (p_out)
   );

   // Output registers only change when a real byte moves in, so a stalled
   // or drained output keeps its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3         <= 1'b0;
         out_data_r <= 8'h00;
         out_tag_r  <= '0;
      end else if (ready3) begin
         v3 <= v2;
         if (v2) begin
            out_data_r <= {q_out, p_out};
            out_tag_r  <= tag2;
         end
      end
   end

   assign out_valid = v3;
   assign out_data  = out_data_r;
   assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_sbox_gf16_inverse.sv
// -----------------------------------------------------------------------------
// tb_sbox_gf16_inverse
//   Self-checking bench for sbox_gf16_inverse. Expected latency/capacity follow
//   the SBOX_INV_MID_REG_EN macro (3 when defined, 2 otherwise). The reference
//   inverse is found by exhaustive search for b with a*b == 1 in GF((2^4)^2).
// -----------------------------------------------------------------------------
module tb_sbox_gf16_inverse;

   localparam int         TAG_W  = 4;
   localparam logic [3:0] LAMBDA = 4'hC;
`ifdef SBOX_INV_MID_REG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [TAG_W-1:0] out_tag;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sbox_gf16_inverse #(.LAMBDA(LAMBDA), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   function automatic logic [3:0] ref_mul16(input logic [3:0] a, input logic [3:0] b);
      logic [7:0] prod;
      prod = 8'h00;
      for (int i = 0; i < 4; i++)
         if (b[i]) prod = prod ^ (8'(a) << i);
      for (int k = 6; k >= 4; k--)
         if (prod[k]) prod = prod ^ (8'h13 << (k - 4));
      return prod[3:0];
   endfunction

   // (a1 x + a0)(b1 x + b0) with x^2 = x + LAMBDA
   function automatic logic [7:0] ref_mul256(input logic [7:0] a, input logic [7:0] b);
      logic [3:0] hh;
      logic [3:0] hi;
      logic [3:0] lo;
      hh = ref_mul16(a[7:4], b[7:4]);
      hi = hh ^ ref_mul16(a[7:4], b[3:0]) ^ ref_mul16(a[3:0], b[7:4]);
      lo = ref_mul16(LAMBDA, hh) ^ ref_mul16(a[3:0], b[3:0]);
      return {hi, lo};
   endfunction

   logic [7:0] ref_inv [256];

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int               checks = 0;
   int               errors = 0;
   logic [11:0]      exp_q[$];
   int               out_count = 0;
   logic             mon_stall = 1'b0;
   logic [7:0]       prev_data;
   logic [TAG_W-1:0] prev_tag;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Handshakes are sampled on the falling edge, half a cycle before the edge
   // that performs the transfer.
   always @(negedge clk) begin
      logic [11:0] e;
      if (!rst_n) begin
         exp_q.delete();
         mon_stall = 1'b0;
      end else begin
         if (mon_stall)
            check("stall_hold", {19'h0, out_valid, out_tag, out_data}, {19'h0, 1'b1, prev_tag, prev_data});
         if (in_valid && in_ready)
            exp_q.push_back({in_tag, ref_inv[in_data]});
         if (out_valid && out_ready) begin
            out_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got %0h expected none", {out_tag, out_data});
            end else begin
               e = exp_q.pop_front();
               check("stream_data", {20'h0, out_tag, out_data}, {20'h0, e});
            end
         end
         mon_stall = out_valid && !out_ready;
         prev_data = out_data;
         prev_tag  = out_tag;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [7:0]       din;
      logic [TAG_W-1:0] tag;
      logic [7:0]       dout;
   } vec_t;

   vec_t vecs [5];

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      int n;
      int seen;
      int gaps;
      int ready_low;
      int accepted;
      int cyc;
      int accepts;
      int stray;
      logic acc;

      ref_inv[0] = 8'h00;
      for (int a = 1; a < 256; a++)
         for (int b = 1; b < 256; b++)
            if (ref_mul256(8'(a), 8'(b)) == 8'h01) ref_inv[a] = 8'(b);

      vecs[0] = '{din: 8'h00, tag: 4'h1, dout: 8'h00};
      vecs[1] = '{din: 8'h01, tag: 4'h2, dout: 8'h01};
      vecs[2] = '{din: 8'h10, tag: 4'h3, dout: 8'hAA};
      vecs[3] = '{din: 8'h02, tag: 4'h4, dout: 8'h09};
      vecs[4] = '{din: 8'h11, tag: 4'hF, dout: 8'hA0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_tag    = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", {31'h0, out_valid}, 32'h0);
      check("reset_out_data", {24'h0, out_data}, 32'h0);
      check("reset_out_tag", {28'h0, out_tag}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("reset_in_ready", {31'h0, in_ready}, 32'h1);

      // Directed vectors with latency measurement
      for (int v = 0; v < 5; v++) begin
         in_valid = 1'b1;
         in_data  = vecs[v].din;
         in_tag   = vecs[v].tag;
         tick();
         in_valid = 1'b0;
         n = 1;
         while (!out_valid && n < 10) begin
            tick();
            n++;
         end
         check("vec_latency", 32'(n), 32'(LAT));
         check("vec_data", {20'h0, out_tag, out_data}, {20'h0, vecs[v].tag, vecs[v].dout});
         tick();
      end

      // All 256 bytes back-to-back, output always ready
      seen = 0;
      gaps = 0;
      ready_low = 0;
      for (int c = 0; c < 256 + LAT + 4; c++) begin
         in_valid = (c < 256);
         in_data  = 8'(c);
         in_tag   = 4'(c);
         #1;
         if (in_valid && !in_ready) ready_low++;
         tick();
         if (out_valid) seen++;
         else if (seen > 0 && seen < 256) gaps++;
      end
      check("stream_ready_low", 32'(ready_low), 32'h0);
      check("stream_seen", 32'(seen), 32'd256);
      check("stream_gaps", 32'(gaps), 32'h0);

      // Random gaps and random backpressure
      in_valid = 1'b0;
      accepted = 0;
      acc      = 1'b0;
      cyc      = 0;
      while (accepted < 4000 && cyc < 40000) begin
         out_ready = ($urandom_range(0, 1) == 1);
         if (!in_valid || acc) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom_range(0, 255));
            in_tag   = 4'($urandom_range(0, 15));
         end
         #1;
         acc = in_valid && in_ready;
         if (acc) accepted++;
         tick();
         cyc++;
      end
      check("rand_accepts", 32'(accepted), 32'd4000);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         tick();
         n++;
      end
      tick();
      check("rand_drain", 32'(exp_q.size()), 32'h0);

      // Fill a stalled pipe, then reset in the middle of the stall
      out_ready = 1'b0;
      in_valid  = 1'b1;
      accepts   = 0;
      for (int c = 0; c < 10; c++) begin
         in_data = 8'($urandom_range(1, 255));
         in_tag  = 4'(c);
         #1;
         if (!in_ready) break;
         accepts++;
         tick();
      end
      check("fill_accepts", 32'(accepts), 32'(LAT));
      check("fill_out_valid", {31'h0, out_valid}, 32'h1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_out_valid", {31'h0, out_valid}, 32'h0);
      check("midreset_out_data", {24'h0, out_data}, 32'h0);
      check("midreset_out_tag", {28'h0, out_tag}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      tick();
      check("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
      stray = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) stray++;
         tick();
      end
      check("post_reset_stray", 32'(stray), 32'h0);

      // One byte after recovery still goes through correctly
      in_valid = 1'b1;
      in_data  = 8'h53;
      in_tag   = 4'h7;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
         tick();
         n++;
      end
      check("recover_latency", 32'(n), 32'(LAT));
      check("recover_data", {20'h0, out_tag, out_data}, {20'h0, 4'h7, ref_inv[8'h53]});
      check("recover_product", {24'h0, ref_mul256(8'h53, out_data)}, 32'h1);
      repeat (3) tick();
      check("final_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
